// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared definitions for the FIFO read-side drain stage.
//   SKID_DEPTH  - number of entries in the skid buffer absorbing read latency
//   occ_t       - skid occupancy type (0..SKID_DEPTH)
//   beat_cnt_w  - width of the burst beat counter for a given BURST_LEN
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // $clog2 alone would give 0 bits for BURST_LEN = 1; keep at least 1 bit.
  function automatic int beat_cnt_w(input int burst_len);
    return (burst_len <= 2) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry push/pop register buffer. Entry 0 is always the head.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, push_data write a word at the tail
//   pop             remove the head (only legal while occ != 0)
//   head            current head word
//   occ             number of stored words, 0..2
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output occ_t             occ
);

  logic [WIDTH-1:0] ent0;
  logic [WIDTH-1:0] ent1;

  // Head only changes on pop or on a push into an empty buffer, so the
  // presented word is stable until it is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            ent0 <= push_data;
          end else begin
            ent0 <= ent1;
            ent1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (1-cycle registered read
// latency) onto a valid/ready stream, framing every BURST_LEN words with
// m_last. Sustains one word per cycle.
// Optional feature: define FIFO_RD_WORD_COUNT_EN to add the 32-bit
// word_count port (count of delivered words, wrapping).
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   fifo_empty_n  FIFO holds at least one word
//   fifo_rd_en    read strobe to the FIFO
//   fifo_rdata    FIFO read data, valid the cycle after fifo_rd_en
//   m_valid, m_ready, m_data, m_last   output stream
//   word_count    delivered-word count (FIFO_RD_WORD_COUNT_EN only)
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty_n,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last
`ifdef FIFO_RD_WORD_COUNT_EN
  ,
  output logic [31:0]      word_count
`endif
);

  localparam int                BEAT_W    = beat_cnt_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  occ_t              occ;
  logic              pending_p1;
  logic              pop;
  logic [2:0]        fill_next;
  logic [BEAT_W-1:0] beat_cnt;

  assign pop = m_valid && m_ready;

  // Words that will be held after this edge; a new strobe is only issued if
  // its word (arriving next cycle) is guaranteed a free skid entry.
  assign fill_next  = {1'b0, occ} + {2'b00, pending_p1} - {2'b00, pop};
  assign fifo_rd_en = rst_n && fifo_empty_n && (fill_next <= 3'(SKID_DEPTH - 1));

  // Stage p1: fifo_rdata is valid in the cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_p1 <= 1'b0;
    else        pending_p1 <= fifo_rd_en;
  end

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pending_p1),
    .push_data (fifo_rdata),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  assign m_valid = (occ != 2'd0);

  // Stage p2: output stream, burst framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (pop) begin
      if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
      else                       beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign m_last = m_valid && (beat_cnt == LAST_BEAT);

`ifdef FIFO_RD_WORD_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   word_count <= '0;
    else if (pop) word_count <= word_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int WIDTH     = 32;
  localparam int BURST_LEN = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             fifo_empty_n;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
`ifdef FIFO_RD_WORD_COUNT_EN
  logic [31:0]      word_count;
`endif

  fifo_stream_reader #(
    .WIDTH     (WIDTH),
    .BURST_LEN (BURST_LEN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_n (fifo_empty_n),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rdata   (fifo_rdata),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last)
`ifdef FIFO_RD_WORD_COUNT_EN
    ,
    .word_count   (word_count)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous FIFO model: registered read data, flag from pointers.
  logic [WIDTH-1:0] fifo_mem [0:255];
  logic [7:0]       wr_ptr = '0;
  logic [7:0]       rd_ptr = '0;

  assign fifo_empty_n = (wr_ptr != rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= fifo_mem[rd_ptr];
      rd_ptr     <= rd_ptr + 8'd1;
    end
  end

  // Skid overflow watch: a word would arrive with both entries full.
  logic ovf_seen = 1'b0;
  always @(posedge clk) begin
    if (rst_n && ((dut.occ == 2'd3) ||
                  (dut.occ == 2'd2 && dut.pending_p1 && !(m_valid && m_ready))))
      ovf_seen <= 1'b1;
  end

  // Scoreboard and per-cycle observations
  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH:0]   obs_q [$];
  int               exp_beat = 0;
  int               vectors = 0;
  int               miscompares = 0;
  int               strobes = 0;
  int               empty_strobes = 0;
  logic             s_rd, s_vld, s_hs;
  logic [WIDTH-1:0] s_data;

  task automatic fifo_push(input logic [WIDTH-1:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 8'd1;
    exp_q.push_back(d);
  endtask

  // One clock: sample at the falling edge, return 1 time unit after rising edge.
  task automatic tick();
    @(negedge clk);
    s_rd   = fifo_rd_en;
    s_vld  = m_valid;
    s_data = m_data;
    s_hs   = m_valid && m_ready;
    if (fifo_rd_en) strobes++;
    if (fifo_rd_en && !fifo_empty_n) empty_strobes++;
    if (s_hs) obs_q.push_back({m_last, m_data});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_beat = 0;
  endtask

  task automatic test_reset();
    m_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({fifo_rd_en, m_valid, m_last, m_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rd=%b vld=%b last=%b data=%h, expected all 0",
               fifo_rd_en, m_valid, m_last, m_data);
    end
    tick();
    tick();
    rst_n = 1'b1;
    exp_beat = 0;
    tick();
    vectors++;
    if ({m_valid, fifo_rd_en, dut.occ, dut.beat_cnt} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: got vld=%b rd=%b occ=%0d beat=%0d, expected 0",
               m_valid, fifo_rd_en, dut.occ, dut.beat_cnt);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp_rd  = 8'b0000_1111;
    logic [7:0] exp_vld = 8'b0011_1100;
    logic [WIDTH:0] got;
    logic [WIDTH-1:0] ed;
    logic el;
    m_ready = 1'b1;
    fifo_push(32'h11); fifo_push(32'h22); fifo_push(32'h33); fifo_push(32'h44);
    for (int c = 0; c < 8; c++) begin
      tick();
      vectors++;
      if (s_rd !== exp_rd[c] || s_vld !== exp_vld[c]) begin
        miscompares++;
        $display("FAIL stream_timing cycle %0d: got rd=%b vld=%b, expected rd=%b vld=%b",
                 c, s_rd, s_vld, exp_rd[c], exp_vld[c]);
      end
    end
    while (obs_q.size() != 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream_extra: got %h, expected nothing", got);
      end else begin
        ed = exp_q.pop_front();
        el = (exp_beat == BURST_LEN - 1);
        exp_beat = (exp_beat + 1) % BURST_LEN;
        if (got !== {el, ed}) begin
          miscompares++;
          $display("FAIL stream_word: got last=%b data=%h, expected last=%b data=%h",
                   got[WIDTH], got[WIDTH-1:0], el, ed);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] got;
    logic [WIDTH-1:0] ed;
    logic el;
    m_ready = 1'b0;
    strobes = 0;
    fifo_push(32'h11); fifo_push(32'h22); fifo_push(32'h33); fifo_push(32'h44);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c >= 2) begin
        vectors++;
        if (s_vld !== 1'b1 || s_data !== 32'h11) begin
          miscompares++;
          $display("FAIL bp_hold cycle %0d: got vld=%b data=%h, expected vld=1 data=00000011",
                   c, s_vld, s_data);
        end
      end
    end
    vectors++;
    if (strobes != 2 || dut.occ !== 2'd2) begin
      miscompares++;
      $display("FAIL bp_strobes: got strobes=%0d occ=%0d, expected 2 and 2", strobes, dut.occ);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      vectors++;
      if (s_hs !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_restart cycle %0d: got handshake=%b, expected 1", c, s_hs);
      end
    end
    tick();
    tick();
    while (obs_q.size() != 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL bp_extra: got %h, expected nothing", got);
      end else begin
        ed = exp_q.pop_front();
        el = (exp_beat == BURST_LEN - 1);
        exp_beat = (exp_beat + 1) % BURST_LEN;
        if (got !== {el, ed}) begin
          miscompares++;
          $display("FAIL bp_word: got last=%b data=%h, expected last=%b data=%h",
                   got[WIDTH], got[WIDTH-1:0], el, ed);
        end
      end
    end
  endtask

  task automatic test_single();
    int vld_cycles = 0;
    logic [WIDTH:0] got;
    logic [WIDTH-1:0] ed;
    logic el;
    m_ready = 1'b1;
    strobes = 0;
    fifo_push(32'hA5);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (s_vld) vld_cycles++;
    end
    vectors++;
    if (strobes != 1 || vld_cycles != 1) begin
      miscompares++;
      $display("FAIL single_word: got strobes=%0d valid_cycles=%0d, expected 1 and 1",
               strobes, vld_cycles);
    end
    while (obs_q.size() != 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL single_extra: got %h, expected nothing", got);
      end else begin
        ed = exp_q.pop_front();
        el = (exp_beat == BURST_LEN - 1);
        exp_beat = (exp_beat + 1) % BURST_LEN;
        if (got !== {el, ed}) begin
          miscompares++;
          $display("FAIL single_data: got last=%b data=%h, expected last=%b data=%h",
                   got[WIDTH], got[WIDTH-1:0], el, ed);
        end
      end
    end
  endtask

  task automatic test_ready_toggle();
    int n_words;
    logic [WIDTH:0] got;
    logic [WIDTH-1:0] ed;
    logic el;
    do_reset();
    for (int i = 0; i < 10; i++) fifo_push(32'h100 + i);
    for (int c = 0; c < 40; c++) begin
      m_ready = (c % 2 == 0);
      tick();
    end
    m_ready = 1'b1;
    n_words = obs_q.size();
    vectors++;
    if (n_words != 10 || dut.beat_cnt !== 2'd2) begin
      miscompares++;
      $display("FAIL toggle_count: got words=%0d beat_cnt=%0d, expected 10 and 2",
               n_words, dut.beat_cnt);
    end
    while (obs_q.size() != 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL toggle_extra: got %h, expected nothing", got);
      end else begin
        ed = exp_q.pop_front();
        el = (exp_beat == BURST_LEN - 1);
        exp_beat = (exp_beat + 1) % BURST_LEN;
        if (got !== {el, ed}) begin
          miscompares++;
          $display("FAIL toggle_word: got last=%b data=%h, expected last=%b data=%h",
                   got[WIDTH], got[WIDTH-1:0], el, ed);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH:0] got;
    logic [WIDTH-1:0] ed;
    logic el;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) fifo_push(32'h51 + i);
    tick();
    tick();
    // One word buffered, one on fifo_rdata this cycle.
    vectors++;
    if (dut.occ !== 2'd1 || dut.pending_p1 !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_setup: got occ=%0d pending=%b, expected 1 and 1",
               dut.occ, dut.pending_p1);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({fifo_rd_en, m_valid, m_last, m_data, dut.occ, dut.pending_p1} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got rd=%b vld=%b last=%b data=%h occ=%0d pend=%b, expected all 0",
               fifo_rd_en, m_valid, m_last, m_data, dut.occ, dut.pending_p1);
    end
    // The buffered and in-flight words are lost; the FIFO has moved past them.
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tick();
    rst_n = 1'b1;
    exp_beat = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) tick();
    vectors++;
    if (obs_q.size() != 3) begin
      miscompares++;
      $display("FAIL mid_count: got %0d words, expected 3", obs_q.size());
    end
    while (obs_q.size() != 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL mid_extra: got %h, expected nothing", got);
      end else begin
        ed = exp_q.pop_front();
        el = (exp_beat == BURST_LEN - 1);
        exp_beat = (exp_beat + 1) % BURST_LEN;
        if (got !== {el, ed}) begin
          miscompares++;
          $display("FAIL mid_word: got last=%b data=%h, expected last=%b data=%h",
                   got[WIDTH], got[WIDTH-1:0], el, ed);
        end
      end
    end
  endtask

`ifdef FIFO_RD_WORD_COUNT_EN
  task automatic test_word_count();
    logic [WIDTH:0] got;
    logic [WIDTH-1:0] ed;
    logic el;
    do_reset();
    vectors++;
    if (word_count !== 32'd0) begin
      miscompares++;
      $display("FAIL wc_reset: got %0d, expected 0", word_count);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 7; i++) fifo_push(32'h700 + i);
    for (int c = 0; c < 14; c++) tick();
    vectors++;
    if (word_count !== 32'd7) begin
      miscompares++;
      $display("FAIL wc_seven: got %0d, expected 7", word_count);
    end
    force dut.word_count = 32'hFFFF_FFFE;
    #1;
    release dut.word_count;
    fifo_push(32'h7A); fifo_push(32'h7B);
    for (int c = 0; c < 8; c++) tick();
    vectors++;
    if (word_count !== 32'd0) begin
      miscompares++;
      $display("FAIL wc_wrap: got %h, expected 00000000", word_count);
    end
    while (obs_q.size() != 0) begin
      got = obs_q.pop_front();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wc_extra: got %h, expected nothing", got);
      end else begin
        ed = exp_q.pop_front();
        el = (exp_beat == BURST_LEN - 1);
        exp_beat = (exp_beat + 1) % BURST_LEN;
        if (got !== {el, ed}) begin
          miscompares++;
          $display("FAIL wc_word: got last=%b data=%h, expected last=%b data=%h",
                   got[WIDTH], got[WIDTH-1:0], el, ed);
        end
      end
    end
  endtask
`endif

  task automatic test_invariants();
    vectors++;
    if (empty_strobes != 0) begin
      miscompares++;
      $display("FAIL strobe_when_empty: got %0d, expected 0", empty_strobes);
    end
    vectors++;
    if (ovf_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL skid_overflow: got %b, expected 0", ovf_seen);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL undelivered: got %0d words left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_single();
    test_ready_toggle();
    test_reset_mid();
`ifdef FIFO_RD_WORD_COUNT_EN
    test_word_count();
`endif
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
